// File: rtl/ann_frame_loader_if.sv
// Bundles the loader's feature stream, network handshake and result signals.
// Ports: in_valid/in_data/in_last/in_ready form the feature stream. vec_out/ann_start/ann_done/ann_out connect to the network.
//        res_valid/res_class/res_vec carry the result. frame_err/timeout are sticky status flags.
// Modports: master = environment side (drives stream and network replies); slave = the loader itself.
interface ann_frame_loader_if #(
  parameter int N_IN  = 30,
  parameter int W     = 10,
  parameter int N_OUT = 3
) ();
  logic                  in_valid;
  logic [W-1:0]          in_data;
  logic                  in_last;
  logic                  in_ready;
  logic [N_IN*W-1:0]     vec_out;
  logic                  ann_start;
  logic                  ann_done;
  logic [N_OUT*W-1:0]    ann_out;
  logic                  res_valid;
  logic [1:0]            res_class;
  logic [N_OUT*W-1:0]    res_vec;
  logic                  frame_err;
  logic                  timeout;

  modport master (
    output in_valid, in_data, in_last, ann_done, ann_out,
    input  in_ready, vec_out, ann_start, res_valid, res_class, res_vec, frame_err, timeout
  );

  modport slave (
    input  in_valid, in_data, in_last, ann_done, ann_out,
    output in_ready, vec_out, ann_start, res_valid, res_class, res_vec, frame_err, timeout
  );
endinterface

// File: rtl/ann_frame_loader.sv
// Assembles a 30-word feature frame from a valid/ready stream, launches the network and reports the arg-max class.
// Ports: Clock, Rst (sync, active-high), ann_if (slave modport of ann_frame_loader_if).
// Latency: last beat -> ann_start 1 cycle; ann_done -> res_valid 1 cycle. in_ready is high only in FILL.
// Optional: define ANN_LOADER_TIMEOUT_EN to add a WAIT-state watchdog (TIMEOUT_CYC cycles, sticky timeout flag).
module ann_frame_loader #(
  parameter int N_IN  = 30,
  parameter int W     = 10,
  parameter int N_OUT = 3
`ifdef ANN_LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input logic               Clock,
  input logic               Rst,
  ann_frame_loader_if.slave ann_if
);

  localparam int                IDX_W    = $clog2(N_IN);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_IN - 1);

  typedef enum logic [1:0] {S_FILL, S_LAUNCH, S_WAIT, S_REPORT} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic                in_ready_q;
  logic                ann_start_q;
  logic                res_valid_q;
  logic [1:0]          res_class_q;
  logic [1:0]          res_class_d;
  logic [N_OUT*W-1:0]  res_vec_q;
  logic                frame_err_q;
  logic [W-1:0]        vec_q [N_IN];
  logic [W-1:0]        best_val;

`ifdef ANN_LOADER_TIMEOUT_EN
  localparam int               CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0]    wd_cnt_q;
  logic                timeout_q;
`endif

  // Arg-max over the incoming neurons; strict '>' keeps the lowest index on ties.
  always_comb begin
    res_class_d = '0;
    best_val    = ann_if.ann_out[0 +: W];
    for (int j = 1; j < N_OUT; j++) begin
      if (ann_if.ann_out[j*W +: W] > best_val) begin
        best_val    = ann_if.ann_out[j*W +: W];
        res_class_d = 2'(j);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q     <= S_FILL;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      ann_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      res_vec_q   <= '0;
      frame_err_q <= 1'b0;
      for (int k = 0; k < N_IN; k++) vec_q[k] <= '0;
`ifdef ANN_LOADER_TIMEOUT_EN
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      // Both pulses last exactly one cycle unless re-armed below.
      ann_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      case (state_q)
        S_FILL: begin
          if (ann_if.in_valid && in_ready_q) begin
            vec_q[idx_q] <= ann_if.in_data;
            if (idx_q == IDX_LAST) begin
              idx_q <= '0;
              if (ann_if.in_last) begin
                state_q     <= S_LAUNCH;
                in_ready_q  <= 1'b0;
                ann_start_q <= 1'b1;
              end else begin
                // Long frame: drop it and treat the next word as word 0.
                frame_err_q <= 1'b1;
              end
            end else if (ann_if.in_last) begin
              // Short frame: drop the partial frame.
              idx_q       <= '0;
              frame_err_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        S_LAUNCH: begin
          state_q <= S_WAIT;
`ifdef ANN_LOADER_TIMEOUT_EN
          wd_cnt_q <= '0;
`endif
        end
        S_WAIT: begin
          if (ann_if.ann_done) begin
            res_vec_q   <= ann_if.ann_out;
            res_class_q <= res_class_d;
            res_valid_q <= 1'b1;
            state_q     <= S_REPORT;
          end
`ifdef ANN_LOADER_TIMEOUT_EN
          else if (wd_cnt_q == WD_LAST) begin
            // Give up on the network; no result is published.
            timeout_q  <= 1'b1;
            state_q    <= S_FILL;
            idx_q      <= '0;
            in_ready_q <= 1'b1;
          end else begin
            wd_cnt_q <= wd_cnt_q + CNT_W'(1);
          end
`endif
        end
        S_REPORT: begin
          state_q    <= S_FILL;
          idx_q      <= '0;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= S_FILL;
          idx_q      <= '0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  for (genvar k = 0; k < N_IN; k++) begin : g_vec
    assign ann_if.vec_out[k*W +: W] = vec_q[k];
  end

  assign ann_if.in_ready  = in_ready_q;
  assign ann_if.ann_start = ann_start_q;
  assign ann_if.res_valid = res_valid_q;
  assign ann_if.res_class = res_class_q;
  assign ann_if.res_vec   = res_vec_q;
  assign ann_if.frame_err = frame_err_q;
`ifdef ANN_LOADER_TIMEOUT_EN
  assign ann_if.timeout   = timeout_q;
`else
  assign ann_if.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_ann_frame_loader.sv
// Self-checking bench for ann_frame_loader: table of network replies plus hand-written framing/reset/watchdog sequences.
// Results are predicted when ann_done is driven (scoreboard queue) and checked when res_valid appears.
// Inputs change and outputs are sampled 1 time unit after the falling clock edge.
module tb_ann_frame_loader;
  localparam int N_IN  = 30;
  localparam int W     = 10;
  localparam int N_OUT = 3;

  typedef struct {
    logic [W-1:0] n0, n1, n2;
    logic [1:0]   cls;
    logic [W-1:0] fill;
    int           incr;
    int           delay;
  } vec_t;

  typedef struct {
    logic [1:0]         cls;
    logic [N_OUT*W-1:0] vec;
  } exp_t;

  logic Clock = 1'b0;
  logic Rst   = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   start_cnt = 0;
  int   res_cnt   = 0;
  exp_t sb[$];
  vec_t tbl[7];

  ann_frame_loader_if #(.N_IN(N_IN), .W(W), .N_OUT(N_OUT)) bus ();

`ifdef ANN_LOADER_TIMEOUT_EN
  ann_frame_loader #(.N_IN(N_IN), .W(W), .N_OUT(N_OUT), .TIMEOUT_CYC(16)) dut (
    .Clock(Clock), .Rst(Rst), .ann_if(bus));
`else
  ann_frame_loader #(.N_IN(N_IN), .W(W), .N_OUT(N_OUT)) dut (
    .Clock(Clock), .Rst(Rst), .ann_if(bus));
`endif

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_vec(input string name, input logic [N_IN*W-1:0] act, input logic [N_IN*W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [N_IN*W-1:0] ramp(input logic [W-1:0] base, input int incr);
    logic [N_IN*W-1:0] v;
    v = '0;
    for (int k = 0; k < N_IN; k++) v[k*W +: W] = W'(int'(base) + k*incr);
    return v;
  endfunction

  // Pulse monitor and scoreboard consumer.
  always @(negedge Clock) begin
    exp_t e;
    if (!Rst) begin
      if (bus.ann_start) start_cnt++;
      if (bus.res_valid) begin
        res_cnt++;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected_res_valid: got res_valid with class %0d, required no result", bus.res_class);
        end else begin
          e = sb.pop_front();
          chk("sb_res_class", int'(bus.res_class), int'(e.cls));
          chk("sb_res_vec", int'(bus.res_vec), int'(e.vec));
        end
      end
    end
  end

  task automatic step();
    @(negedge Clock);
    #1;
  endtask

  task automatic send_words(input int n, input int last_at, input logic [W-1:0] base, input int incr);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'(int'(base) + i*incr);
      bus.in_last  = (i == last_at);
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"},  int'(bus.in_ready), 1);
    chk({tag, "_ann_start"}, int'(bus.ann_start), 0);
    chk({tag, "_res_valid"}, int'(bus.res_valid), 0);
    chk({tag, "_res_class"}, int'(bus.res_class), 0);
    chk({tag, "_res_vec"},   int'(bus.res_vec), 0);
    chk({tag, "_frame_err"}, int'(bus.frame_err), 0);
    chk({tag, "_timeout"},   int'(bus.timeout), 0);
    chk_vec({tag, "_vec_out"}, bus.vec_out, '0);
  endtask

  // Sends a well-formed frame; returns sampling in the first WAIT cycle.
  task automatic run_frame(input logic [W-1:0] base, input int incr, input string tag);
    int s0 = start_cnt;
    chk({tag, "_in_ready_pre"}, int'(bus.in_ready), 1);
    send_words(N_IN, N_IN - 1, base, incr);
    chk({tag, "_ann_start"}, int'(bus.ann_start), 1);
    chk({tag, "_in_ready_launch"}, int'(bus.in_ready), 0);
    chk_vec({tag, "_vec_out"}, bus.vec_out, ramp(base, incr));
    step();
    chk({tag, "_start_once"}, start_cnt - s0, 1);
    chk({tag, "_start_low"}, int'(bus.ann_start), 0);
  endtask

  task automatic idle_wait(input int n, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0) bad++;
    end
    chk({tag, "_wait_quiet"}, bad, 0);
  endtask

  task automatic respond(input logic [W-1:0] n0, input logic [W-1:0] n1, input logic [W-1:0] n2,
                         input logic [1:0] cls, input string tag);
    exp_t e;
    int   r0 = res_cnt;
    e.cls = cls;
    e.vec = {n2, n1, n0};
    bus.ann_out  = {n2, n1, n0};
    bus.ann_done = 1'b1;
    sb.push_back(e);
    step();
    bus.ann_done = 1'b0;
    chk({tag, "_res_valid"}, int'(bus.res_valid), 1);
    chk({tag, "_res_cnt"}, res_cnt - r0, 1);
    step();
    chk({tag, "_res_valid_low"}, int'(bus.res_valid), 0);
    chk({tag, "_in_ready_back"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    int s0, r0, bad;
    tbl[0] = '{n0: 10'd0,    n1: 10'd0,    n2: 10'd1000, cls: 2'd2, fill: 10'd200, incr: 0,  delay: 9};
    tbl[1] = '{n0: 10'd500,  n1: 10'd500,  n2: 10'd100,  cls: 2'd0, fill: 10'd1,   incr: 3,  delay: 2};
    tbl[2] = '{n0: 10'd0,    n1: 10'd0,    n2: 10'd0,    cls: 2'd0, fill: 10'd1023, incr: 0, delay: 0};
    tbl[3] = '{n0: 10'd3,    n1: 10'd1023, n2: 10'd1023, cls: 2'd1, fill: 10'd17,  incr: 31, delay: 5};
    tbl[4] = '{n0: 10'd1023, n1: 10'd1022, n2: 10'd1023, cls: 2'd0, fill: 10'd900, incr: -7, delay: 12};
    tbl[5] = '{n0: 10'd1,    n1: 10'd2,    n2: 10'd3,    cls: 2'd2, fill: 10'd5,   incr: 1,  delay: 1};
    tbl[6] = '{n0: 10'd7,    n1: 10'd9,    n2: 10'd8,    cls: 2'd1, fill: 10'd64,  incr: 2,  delay: 3};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.ann_done = 1'b0;
    bus.ann_out  = '0;
    Rst = 1'b1;
    repeat (3) step();
    reset_checks("reset");
    Rst = 1'b0;
    step();

    // Table of frames and network replies.
    for (int t = 0; t < 7; t++) begin
      run_frame(tbl[t].fill, tbl[t].incr, $sformatf("tbl%0d", t));
      idle_wait(tbl[t].delay, $sformatf("tbl%0d", t));
      respond(tbl[t].n0, tbl[t].n1, tbl[t].n2, tbl[t].cls, $sformatf("tbl%0d", t));
    end

    // Short frame: in_last on the 5th beat.
    s0 = start_cnt;
    send_words(5, 4, 10'd3, 1);
    repeat (3) step();
    chk("short_frame_err", int'(bus.frame_err), 1);
    chk("short_no_start", start_cnt - s0, 0);
    chk("short_in_ready", int'(bus.in_ready), 1);
    chk("hold_res_class", int'(bus.res_class), int'(tbl[6].cls));
    chk("hold_res_vec", int'(bus.res_vec), int'({tbl[6].n2, tbl[6].n1, tbl[6].n0}));

    // ann_done while filling must be ignored.
    r0 = res_cnt;
    bus.ann_out  = {10'd1, 10'd2, 10'd3};
    bus.ann_done = 1'b1;
    repeat (2) step();
    bus.ann_done = 1'b0;
    step();
    chk("done_in_fill_ignored", res_cnt - r0, 0);

    run_frame(10'd40, 3, "after_short");
    idle_wait(4, "after_short");
    respond(10'd50, 10'd60, 10'd70, 2'd2, "after_short");

    // Reset in the middle of a frame.
    send_words(12, -1, 10'd100, 1);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    reset_checks("midframe_rst");
    step();
    run_frame(10'd0, 0, "post_rst");
    chk("post_rst_frame_err", int'(bus.frame_err), 0);
    respond(10'd300, 10'd301, 10'd299, 2'd1, "post_rst");

    // Reset during WAIT: no result afterwards, vector cleared.
    run_frame(10'd77, 0, "wait_rst");
    idle_wait(3, "wait_rst");
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("wait_rst_in_ready", int'(bus.in_ready), 1);
    chk_vec("wait_rst_vec_out", bus.vec_out, '0);
    r0 = res_cnt;
    bus.ann_done = 1'b1;
    repeat (2) step();
    bus.ann_done = 1'b0;
    step();
    chk("wait_rst_no_result", res_cnt - r0, 0);

    // Long frame: 30 beats without in_last, then a proper frame.
    s0 = start_cnt;
    send_words(N_IN, -1, 10'd5, 0);
    step();
    chk("long_frame_err", int'(bus.frame_err), 1);
    chk("long_no_start", start_cnt - s0, 0);
    run_frame(10'd9, 0, "after_long");
    respond(10'd4, 10'd4, 10'd4, 2'd0, "after_long");

`ifdef ANN_LOADER_TIMEOUT_EN
    r0 = res_cnt;
    run_frame(10'd123, 1, "wd");
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.in_ready !== 1'b0) bad++;
    end
    chk("wd_wait_in_ready", bad, 0);
    chk("wd_timeout_before", int'(bus.timeout), 0);
    step();
    chk("wd_timeout_set", int'(bus.timeout), 1);
    chk("wd_in_ready_back", int'(bus.in_ready), 1);
    chk("wd_res_valid", int'(bus.res_valid), 0);
    repeat (3) step();
    chk("wd_no_result", res_cnt - r0, 0);
    chk("wd_timeout_sticky", int'(bus.timeout), 1);
`else
    run_frame(10'd123, 1, "nowd");
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.in_ready !== 1'b0 || bus.timeout !== 1'b0) bad++;
    end
    chk("nowd_still_waiting", bad, 0);
    respond(10'd8, 10'd800, 10'd80, 2'd1, "nowd");
    chk("nowd_timeout", int'(bus.timeout), 0);
`endif

    step();
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
